// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM state type, parameter ranges and width helper for the SPI master
package spi_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_e;
  localparam int unsigned DATA_W_MIN = 4;
  localparam int unsigned DATA_W_MAX = 32;
  localparam int unsigned DIV_MIN = 2;
  localparam int unsigned DIV_MAX = 65535;
  localparam int unsigned NUM_SS_MAX = 16;
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/spi_clk_gen.sv
// spi_clk_gen: half-period divider producing the tick and leading/trailing sclk edge strobes
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic act_i,
  output logic tick_o,
  output logic lead_o,
  output logic trail_o
);
  localparam int unsigned CW = cnt_w(DIV);
  logic [CW-1:0] cnt_q, cnt_d;
  logic ph_q, ph_d;
  logic edge_s;
  // the counter wraps on every tick, so each state change restarts it at 0
  always_comb begin
    tick_o = cnt_q == CW'(DIV - 1);
    edge_s = tick_o && act_i;
    lead_o = edge_s && !ph_q;
    trail_o = edge_s && ph_q;
    cnt_d = (!en_i || tick_o) ? '0 : cnt_q + 1'b1;
    ph_d = en_i ? ph_q ^ edge_s : 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ph_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ph_q <= ph_d;
    end
  end
endmodule

// File: rtl/spi_master_p.sv
// spi_master_p: single-frame SPI master with configurable mode, divider and slave selects
module spi_master_p
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DIV = 4,
  parameter int unsigned NUM_SS = 4,
  parameter bit CPOL = 1'b0,
  parameter bit CPHA = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [DATA_W-1:0]         tx_data,
  input  logic [cnt_w(NUM_SS)-1:0]  ss_sel,
  output logic                      busy,
  output logic                      done,
  output logic [DATA_W-1:0]         rx_data,
  output logic                      sclk,
  output logic                      mosi,
  output logic [NUM_SS-1:0]         ss_n,
  input  logic                      miso
);
  localparam int unsigned BW = cnt_w(DATA_W);
  if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX || DIV < DIV_MIN || DIV > DIV_MAX ||
      NUM_SS < 1 || NUM_SS > NUM_SS_MAX) begin : g_param_err
    $error("spi_master_p: parameter out of range");
  end
  state_e state_q, state_d;
  logic [cnt_w(NUM_SS)-1:0] sel_q, sel_d;
  logic [DATA_W-1:0] tx_q, tx_d, rs_q, rs_d, rx_q, rx_d;
  logic [BW-1:0] bit_q, bit_d;
  logic arm_q, done_q, done_d, sclk_q, sclk_d, mosi_q, mosi_d;
  logic tick, lead, trail, accept;
  spi_clk_gen #(.DIV(DIV)) u_clk_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (busy),
    .act_i   (state_q == SETUP || state_q == XFER),
    .tick_o  (tick),
    .lead_o  (lead),
    .trail_o (trail)
  );
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign rx_data = rx_q;
  assign sclk = sclk_q;
  assign mosi = mosi_q;
  assign ss_n = busy ? ~(NUM_SS'(1) << sel_q) : '1;
  // arm_q blocks acceptance on the first edge after reset; done_q blocks it in the done cycle
  assign accept = start && arm_q && !done_q;
  always_comb begin
    state_d = state_q;
    done_d = 1'b0;
    sel_d = sel_q;
    tx_d = tx_q;
    mosi_d = mosi_q;
    rs_d = rs_q;
    rx_d = rx_q;
    bit_d = bit_q;
    sclk_d = sclk_q ^ (lead || trail);
    if (CPHA ? lead : trail) {mosi_d, tx_d} = {tx_q, 1'b0};
    if (CPHA ? trail : lead) rs_d = {rs_q[DATA_W-2:0], miso};
    if (trail) bit_d = bit_q + 1'b1;
    case (state_q)
      IDLE: if (accept) begin
        state_d = SETUP;
        sel_d = (32'(ss_sel) < NUM_SS) ? ss_sel : '0;
        {mosi_d, tx_d} = CPHA ? {1'b0, tx_data} : {tx_data, 1'b0};
        bit_d = '0;
        rs_d = '0;
      end
      SETUP: if (tick) state_d = XFER;
      XFER: if (trail && bit_q == BW'(DATA_W - 1)) state_d = HOLD;
      HOLD: if (tick) begin
        state_d = IDLE;
        done_d = 1'b1;
        rx_d = rs_q;
        mosi_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      arm_q <= 1'b0;
      done_q <= 1'b0;
      sel_q <= '0;
      tx_q <= '0;
      rs_q <= '0;
      rx_q <= '0;
      bit_q <= '0;
      sclk_q <= CPOL;
      mosi_q <= 1'b0;
    end else begin
      state_q <= state_d;
      arm_q <= 1'b1;
      done_q <= done_d;
      sel_q <= sel_d;
      tx_q <= tx_d;
      rs_q <= rs_d;
      rx_q <= rx_d;
      bit_q <= bit_d;
      sclk_q <= sclk_d;
      mosi_q <= mosi_d;
    end
  end
endmodule

// File: tb/tb_spi_master_p.sv
// tb_spi_master_p: randomized checks of three SPI master configurations against timing/data rules
module tb_spi_master_p;
  localparam int LAT8 = 1 + (2 * 8 + 1) * 4;
  localparam int LAT16 = 1 + (2 * 16 + 1) * 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int cmp = 0;
  int bad = 0;
  logic start_a = 1'b0;
  logic [7:0] tx_a = '0;
  logic [1:0] sel_a = '0;
  logic busy_a, done_a, sclk_a, mosi_a;
  logic [7:0] rx_a;
  logic [3:0] ssn_a;
  spi_master_p u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .tx_data(tx_a), .ss_sel(sel_a),
    .busy(busy_a), .done(done_a), .rx_data(rx_a), .sclk(sclk_a), .mosi(mosi_a),
    .ss_n(ssn_a), .miso(mosi_a)
  );
  logic start_b = 1'b0;
  logic [15:0] tx_b = '0;
  logic [1:0] sel_b = '0;
  logic busy_b, done_b, sclk_b, mosi_b;
  logic [15:0] rx_b;
  logic [2:0] ssn_b;
  spi_master_p #(.DATA_W(16), .DIV(2), .NUM_SS(3)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .tx_data(tx_b), .ss_sel(sel_b),
    .busy(busy_b), .done(done_b), .rx_data(rx_b), .sclk(sclk_b), .mosi(mosi_b),
    .ss_n(ssn_b), .miso(mosi_b)
  );
  logic start_c = 1'b0;
  logic [7:0] tx_c = '0;
  logic [1:0] sel_c = '0;
  logic busy_c, done_c, sclk_c, mosi_c;
  logic [7:0] rx_c;
  logic [3:0] ssn_c;
  logic miso_c = 1'b0;
  spi_master_p #(.CPOL(1'b1), .CPHA(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .tx_data(tx_c), .ss_sel(sel_c),
    .busy(busy_c), .done(done_c), .rx_data(rx_c), .sclk(sclk_c), .mosi(mosi_c),
    .ss_n(ssn_c), .miso(miso_c)
  );
  // mode-3 slave: drives on falling sclk, captures on rising sclk; also watches mosi and idle sclk
  logic [7:0] s_val = '0, s_out = '0, s_in = '0;
  logic ps_c = 1'b1, pm_c = 1'b0;
  int mosi_chg = 0, mosi_bad = 0, idle_bad = 0;
  always @(negedge clk) begin
    if (&ssn_c) s_out <= s_val;
    else begin
      if (ps_c && !sclk_c) begin
        miso_c <= s_out[7];
        s_out <= s_out << 1;
      end
      if (!ps_c && sclk_c) s_in <= {s_in[6:0], mosi_c};
    end
    if (busy_c && mosi_c !== pm_c) begin
      mosi_chg <= mosi_chg + 1;
      if (!(ps_c && !sclk_c)) mosi_bad <= mosi_bad + 1;
    end
    if (!busy_c && sclk_c !== 1'b1) idle_bad <= idle_bad + 1;
    ps_c <= sclk_c;
    pm_c <= mosi_c;
  end
  task automatic run_a(input logic [7:0] tx, input logic [1:0] sel, output int lat, output logic [3:0] m);
    repeat (2) @(negedge clk);
    tx_a = tx; sel_a = sel; start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    lat = -1; m = 'x;
    for (int n = 1; n <= 300 && lat < 0; n++) begin
      if (n == 20) m = ssn_a;
      if (done_a) lat = n; else begin @(posedge clk); #1; end
    end
  endtask
  task automatic run_b(input logic [15:0] tx, input logic [1:0] sel, output int lat, output logic [2:0] m);
    repeat (2) @(negedge clk);
    tx_b = tx; sel_b = sel; start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    lat = -1; m = 'x;
    for (int n = 1; n <= 300 && lat < 0; n++) begin
      if (n == 20) m = ssn_b;
      if (done_b) lat = n; else begin @(posedge clk); #1; end
    end
  endtask
  task automatic run_c(input logic [7:0] tx, input logic [7:0] sv, input logic [1:0] sel, output int lat, output logic [3:0] m);
    s_val = sv;
    repeat (2) @(negedge clk);
    tx_c = tx; sel_c = sel; start_c = 1'b1;
    @(posedge clk); #1 start_c = 1'b0;
    lat = -1; m = 'x;
    for (int n = 1; n <= 300 && lat < 0; n++) begin
      if (n == 20) m = ssn_c;
      if (done_c) lat = n; else begin @(posedge clk); #1; end
    end
  endtask
  task automatic test_reset;
    int n;
    repeat (3) @(negedge clk);
    cmp++; if ({busy_a, done_a, mosi_a, sclk_a, ssn_a, rx_a} !== {4'b0000, 4'hF, 8'h00}) begin
      bad++; $display("FAIL reset_a: got %b expected %b", {busy_a, done_a, mosi_a, sclk_a, ssn_a, rx_a}, {4'b0000, 4'hF, 8'h00}); end
    cmp++; if ({busy_b, done_b, mosi_b, sclk_b, ssn_b, rx_b} !== {4'b0000, 3'b111, 16'h0}) begin
      bad++; $display("FAIL reset_b: got %b expected %b", {busy_b, done_b, mosi_b, sclk_b, ssn_b, rx_b}, {4'b0000, 3'b111, 16'h0}); end
    cmp++; if ({busy_c, done_c, mosi_c, sclk_c, ssn_c, rx_c} !== {4'b0001, 4'hF, 8'h00}) begin
      bad++; $display("FAIL reset_c: got %b expected %b", {busy_c, done_c, mosi_c, sclk_c, ssn_c, rx_c}, {4'b0001, 4'hF, 8'h00}); end
    tx_a = 8'h5A; sel_a = 2'd1; start_a = 1'b1; rst_n = 1'b1;
    @(posedge clk); #1;
    cmp++; if (busy_a !== 1'b0) begin bad++; $display("FAIL first_edge_ignored: got busy=%b expected 0", busy_a); end
    @(posedge clk); #1 start_a = 1'b0;
    cmp++; if ({busy_a, ssn_a} !== 5'b1_1101) begin bad++; $display("FAIL second_edge_start: got %b expected 11101", {busy_a, ssn_a}); end
    n = 1;
    while (!done_a && n < 300) begin @(posedge clk); #1; n++; end
    cmp++; if (n !== LAT8 || rx_a !== 8'h5A) begin
      bad++; $display("FAIL post_reset_xfer: got lat=%0d rx=%h expected lat=%0d rx=5a", n, rx_a, LAT8); end
  endtask
  task automatic test_loopback;
    int lat;
    logic [3:0] m, e;
    logic [7:0] tx;
    logic [1:0] sel;
    run_a(8'hA5, 2'd2, lat, m);
    cmp++; if (lat !== LAT8) begin bad++; $display("FAIL a5_latency: got %0d expected %0d", lat, LAT8); end
    cmp++; if (m !== 4'b1011) begin bad++; $display("FAIL a5_ss_n: got %b expected 1011", m); end
    cmp++; if (rx_a !== 8'hA5) begin bad++; $display("FAIL a5_rx: got %h expected a5", rx_a); end
    cmp++; if ({busy_a, ssn_a} !== 5'b0_1111) begin bad++; $display("FAIL a5_done_state: got %b expected 01111", {busy_a, ssn_a}); end
    @(posedge clk); #1;
    cmp++; if ({done_a, rx_a} !== {1'b0, 8'hA5}) begin bad++; $display("FAIL done_single: got %b expected 0_a5", {done_a, rx_a}); end
    repeat (4) begin
      tx = 8'($urandom); sel = 2'($urandom_range(0, 3));
      e = 4'hF; e[sel] = 1'b0;
      run_a(tx, sel, lat, m);
      cmp++; if ({lat, m, rx_a} !== {LAT8, e, tx}) begin
        bad++; $display("FAIL loopback_rand: got lat=%0d ss=%b rx=%h expected lat=%0d ss=%b rx=%h", lat, m, rx_a, LAT8, e, tx); end
    end
  endtask
  task automatic test_busy_ignore;
    int n, woke;
    logic [7:0] tx0;
    tx0 = 8'($urandom_range(1, 254));
    repeat (2) @(negedge clk);
    tx_a = tx0; sel_a = 2'd0; start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    repeat (9) @(posedge clk);
    #1 tx_a = 8'hFF; sel_a = 2'd3; start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    cmp++; if (ssn_a !== 4'b1110) begin bad++; $display("FAIL ignore_ss: got %b expected 1110", ssn_a); end
    n = 11;
    while (!done_a && n < 300) begin @(posedge clk); #1; n++; end
    cmp++; if (n !== LAT8 || rx_a !== tx0) begin
      bad++; $display("FAIL ignore_frame: got lat=%0d rx=%h expected lat=%0d rx=%h", n, rx_a, LAT8, tx0); end
    woke = 0;
    repeat (20) begin @(posedge clk); #1; if (busy_a) woke++; end
    cmp++; if (woke !== 0) begin bad++; $display("FAIL ignore_no_second: got %0d busy cycles expected 0", woke); end
  endtask
  task automatic test_reset_mid;
    int pulses;
    repeat (2) @(negedge clk);
    tx_a = 8'h3E; sel_a = 2'd1; start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    cmp++; if ({busy_a, sclk_a} !== 2'b11) begin bad++; $display("FAIL pre_reset: got %b expected 11", {busy_a, sclk_a}); end
    #2 rst_n = 1'b0;
    #1;
    cmp++; if ({busy_a, done_a, sclk_a, ssn_a, rx_a} !== {3'b000, 4'hF, 8'h00}) begin
      bad++; $display("FAIL reset_abort: got %b expected %b", {busy_a, done_a, sclk_a, ssn_a, rx_a}, {3'b000, 4'hF, 8'h00}); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (100) begin @(posedge clk); #1; if (done_a) pulses++; end
    cmp++; if (pulses !== 0 || rx_a !== 8'h00) begin
      bad++; $display("FAIL reset_no_done: got pulses=%0d rx=%h expected 0 00", pulses, rx_a); end
  endtask
  task automatic test_back_to_back;
    int n;
    logic [7:0] t1, t2;
    t1 = 8'($urandom); t2 = 8'($urandom);
    repeat (2) @(negedge clk);
    tx_a = t1; sel_a = 2'd1; start_a = 1'b1;
    @(posedge clk); #1;
    n = 1;
    while (!done_a && n < 300) begin @(posedge clk); #1; n++; end
    cmp++; if ({n, rx_a, busy_a, ssn_a} !== {LAT8, t1, 1'b0, 4'hF}) begin
      bad++; $display("FAIL b2b_first: got lat=%0d rx=%h busy=%b ss=%b expected %0d %h 0 1111", n, rx_a, busy_a, ssn_a, LAT8, t1); end
    tx_a = t2;
    @(posedge clk); #1;
    cmp++; if ({done_a, busy_a, ssn_a} !== 6'b00_1111) begin bad++; $display("FAIL b2b_gap: got %b expected 001111", {done_a, busy_a, ssn_a}); end
    @(posedge clk); #1 start_a = 1'b0;
    cmp++; if ({busy_a, ssn_a} !== 5'b1_1101) begin bad++; $display("FAIL b2b_restart: got %b expected 11101", {busy_a, ssn_a}); end
    n = 1;
    while (!done_a && n < 300) begin @(posedge clk); #1; n++; end
    cmp++; if ({n, rx_a} !== {LAT8, t2}) begin
      bad++; $display("FAIL b2b_second: got lat=%0d rx=%h expected %0d %h", n, rx_a, LAT8, t2); end
  endtask
  task automatic test_wide;
    int lat;
    logic [2:0] m, e;
    logic [15:0] tx;
    logic [1:0] sel;
    run_b(16'hBEEF, 2'd3, lat, m);
    cmp++; if ({lat, m, rx_b} !== {LAT16, 3'b110, 16'hBEEF}) begin
      bad++; $display("FAIL beef: got lat=%0d ss=%b rx=%h expected %0d 110 beef", lat, m, rx_b, LAT16); end
    repeat (3) begin
      tx = 16'($urandom); sel = 2'($urandom_range(0, 3));
      e = 3'b111; e[(sel < 2'd3) ? sel : 2'd0] = 1'b0;
      run_b(tx, sel, lat, m);
      cmp++; if ({lat, m, rx_b} !== {LAT16, e, tx}) begin
        bad++; $display("FAIL wide_rand: got lat=%0d ss=%b rx=%h expected %0d %b %h", lat, m, rx_b, LAT16, e, tx); end
    end
  endtask
  task automatic test_cpol_cpha;
    int lat;
    logic [3:0] m, e;
    logic [7:0] tx, sv;
    logic [1:0] sel;
    cmp++; if (sclk_c !== 1'b1) begin bad++; $display("FAIL c_idle_sclk: got %b expected 1", sclk_c); end
    run_c(8'h96, 8'h3C, 2'd0, lat, m);
    cmp++; if ({lat, m, rx_c, s_in} !== {LAT8, 4'b1110, 8'h3C, 8'h96}) begin
      bad++; $display("FAIL c_3c: got lat=%0d ss=%b rx=%h slave=%h expected %0d 1110 3c 96", lat, m, rx_c, s_in, LAT8); end
    repeat (3) begin
      tx = 8'($urandom); sv = 8'($urandom); sel = 2'($urandom_range(0, 3));
      e = 4'hF; e[sel] = 1'b0;
      run_c(tx, sv, sel, lat, m);
      cmp++; if ({lat, m, rx_c, s_in} !== {LAT8, e, sv, tx}) begin
        bad++; $display("FAIL c_rand: got lat=%0d ss=%b rx=%h slave=%h expected %0d %b %h %h", lat, m, rx_c, s_in, LAT8, e, sv, tx); end
    end
    @(negedge clk);
    cmp++; if (mosi_bad !== 0 || mosi_chg == 0) begin
      bad++; $display("FAIL c_mosi_edges: got bad=%0d changes=%0d expected 0 and >0", mosi_bad, mosi_chg); end
    cmp++; if (idle_bad !== 0) begin bad++; $display("FAIL c_idle_high: got %0d low idle cycles expected 0", idle_bad); end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_loopback();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    test_wide();
    test_cpol_cpha();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
